fb_port_arbiter: RTL and testbench
==================================

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning write-queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter MAX_RD_BURST, default 8, meaning consecutive read grants before a queued write is forced.
REQ-003 SHALL have port clk_50  in  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  in  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port wr_req  in  1  meaning video-input write request; wr_addr in 16, wr_data in 32, wr_be in 4 carry address, pixel data and byte enables.
REQ-006 SHALL have port wr_ready  out  1  meaning queue not full; a write is accepted on an edge where wr_req and wr_ready are both 1.
REQ-007 SHALL have port wr_drop  out  1  meaning one-cycle pulse on a cycle after wr_req was high while wr_ready was 0.
REQ-008 SHALL have port rd_req  in  1  meaning VGA read request; rd_addr in 16 carries the address.
REQ-009 SHALL have port rd_ready  out  1  meaning read granted this cycle (combinational).
REQ-010 SHALL have port rd_data  out  32  meaning returned word, qualified by rd_valid out 1.
REQ-011 SHALL have RAM-side ports: ram_wraddress out 16, ram_data out 32, ram_byteena out 4, ram_wren out 1, ram_rdaddress out 16, ram_rden out 1, ram_q in 32 (one-cycle read latency).
REQ-012 SHALL have ports stat_drop_cnt out 16 and stat_force_cnt out 16, meaning the dropped-write count and the forced-write count.

Function
REQ-013 SHALL decide each cycle, in priority order: force-write if rd_streak==MAX_RD_BURST and queue non-empty; else read if rd_req; else write if queue non-empty; else idle.
REQ-014 SHALL drive rd_ready = rd_req AND the cycle is not a force-write cycle.
REQ-015 SHALL register the decision into a state: IDLE, RD, WR, FORCE_WR; the state holds exactly one cycle and the next state is always the next cycle's decision.
REQ-016 SHALL drive ram_rden=1 with ram_rdaddress equal to the granted rd_addr during state RD only.
REQ-017 SHALL drive ram_wren=1 with the popped head entry on ram_wraddress, ram_data and ram_byteena during WR or FORCE_WR only; ram_wren and ram_rden are never both 1.
REQ-018 SHALL capture ram_q into rd_data and pulse rd_valid one cycle after an RD cycle; read latency is 3 cycles from the accepting edge (edge T accepts, rd_valid is high in the cycle after edge T+2).
REQ-019 SHALL keep rd_data unchanged while rd_valid=0.
REQ-020 SHALL increment rd_streak on each read grant (saturating at MAX_RD_BURST) and clear it on any non-read cycle.
REQ-021 SHALL pop the queue on the decision edge of a write; a push and pop on the same edge leave the count unchanged, and with the queue full that push is refused.
REQ-022 SHALL drive wr_ready = (count < FIFO_DEPTH) from registered count; pointers wrap modulo FIFO_DEPTH; an empty queue never issues a write.
REQ-023 SHALL leave wr_addr and rd_addr unmodified, with no address arithmetic.

Reset
REQ-024 SHALL, on any edge with reset_n=0 (including mid-operation), empty the queue, discard the in-flight read, set the state to IDLE, clear rd_streak, and force rd_valid, rd_data, all ram_* outputs, wr_drop and both stat counters to 0.
REQ-025 SHALL drive wr_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, when macro FB_ARB_STATS_EN is defined, increment stat_drop_cnt on each wr_drop pulse and stat_force_cnt on each FORCE_WR entry, each saturating at 0xFFFF.
REQ-027 SHALL, when FB_ARB_STATS_EN is undefined, omit the counter logic and tie stat_drop_cnt and stat_force_cnt to 0; arbitration behaviour is identical in both builds.

Verification
REQ-028 SHALL cover: a single rd_req at addr 0x0010 with the RAM model holding 0xCAFEBABE -> rd_ready high, ram_rden for 1 cycle, rd_data=0xCAFEBABE with rd_valid 3 cycles later.
REQ-029 SHALL cover: 4 writes while rd_req is held low -> ram_wren pulses 4 times in FIFO order with matching addr, data and be.
REQ-030 SHALL cover: rd_req held high continuously with 1 queued write -> 8 read grants, then rd_ready=0 and FORCE_WR for 1 cycle, then reads resume; stat_force_cnt=1 when FB_ARB_STATS_EN is defined.
REQ-031 SHALL cover: 5 back-to-back writes with rd_req held high and the queue full -> 5th write refused, wr_drop pulses once, stat_drop_cnt=1 (or 0 when the macro is undefined).
REQ-032 SHALL cover: reset_n low one cycle after a read is accepted -> no rd_valid, queue empty, all outputs 0, wr_ready=1 afterwards.
REQ-033 SHALL cover: push and pop on the same edge with count=2 -> count stays 2 and data ordering is preserved.

Source files
------------

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if
//   Bundles the signals between the frame-buffer port arbiter and the blocks
//   around it. Those blocks are the video-input writer, the VGA reader, the
//   dual-port RAM and the statistics readout.
//
// Signals
//   wr_req / wr_addr[15:0] / wr_data[31:0] / wr_be[3:0]
//                      video-input write request and payload
//   wr_ready           write queue has room; accept on wr_req & wr_ready
//   wr_drop            one-cycle pulse after a write was offered while full
//   rd_req / rd_addr[15:0]
//                      VGA read request
//   rd_ready           read granted this cycle (combinational)
//   rd_data[31:0] / rd_valid
//                      returned word
//   ram_wraddress / ram_data / ram_byteena / ram_wren
//                      RAM write port
//   ram_rdaddress / ram_rden / ram_q
//                      RAM read port (ram_q has one-cycle latency)
//   stat_drop_cnt / stat_force_cnt
//                      dropped-write and forced-write counters
//
// Modports
//   slave  : the arbiter
//   master : the surrounding clients and the RAM
interface fb_port_arbiter_if;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_ready;
  logic        wr_drop;

  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_valid;

  logic [15:0] ram_wraddress;
  logic [31:0] ram_data;
  logic [3:0]  ram_byteena;
  logic        ram_wren;
  logic [15:0] ram_rdaddress;
  logic        ram_rden;
  logic [31:0] ram_q;

  logic [15:0] stat_drop_cnt;
  logic [15:0] stat_force_cnt;

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr, ram_q,
    output wr_ready, wr_drop, rd_ready, rd_data, rd_valid,
           ram_wraddress, ram_data, ram_byteena, ram_wren,
           ram_rdaddress, ram_rden, stat_drop_cnt, stat_force_cnt
  );

  modport master (
    output wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr, ram_q,
    input  wr_ready, wr_drop, rd_ready, rd_data, rd_valid,
           ram_wraddress, ram_data, ram_byteena, ram_wren,
           ram_rdaddress, ram_rden, stat_drop_cnt, stat_force_cnt
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares one RAM between a queued video-input writer and a VGA reader.
//   Reads win by default. After MAX_RD_BURST back-to-back read grants, a
//   queued write is forced through so the writer cannot starve.
//   Read latency is 3 cycles from the accepting edge.
//
// Parameters
//   FIFO_DEPTH    write-queue entries (power of 2, 2..16)
//   MAX_RD_BURST  consecutive read grants before a queued write is forced
//
// Ports
//   clk_50   single system clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      fb_port_arbiter_if.slave (write, read, RAM and stats signals)
//
// Build option
//   FB_ARB_STATS_EN  when defined, enables the saturating drop/force counters.
//                    When undefined, both counters read 0.
module fb_port_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_RD_BURST = 8
) (
  input logic              clk_50,
  input logic              reset_n,
  fb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_RD_BURST + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, FORCE_WR} state_t;

  state_t        state;
  state_t        decision;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] rd_streak;
  logic          rd_pending;
  logic          queue_empty;
  logic          streak_full;
  logic          push;
  logic          pop;

  logic [15:0] q_addr [FIFO_DEPTH];
  logic [31:0] q_data [FIFO_DEPTH];
  logic [3:0]  q_be   [FIFO_DEPTH];

  assign queue_empty  = (count == '0);
  assign streak_full  = (rd_streak == SW'(MAX_RD_BURST));
  assign bus.wr_ready = (count < CW'(FIFO_DEPTH));
  assign push         = bus.wr_req && bus.wr_ready;
  assign pop          = (decision == WR) || (decision == FORCE_WR);
  assign bus.rd_ready = bus.rd_req && (decision != FORCE_WR);

  // Per-cycle arbitration. A forced write beats a pending read.
  always_comb begin
    decision = IDLE;
    if (streak_full && !queue_empty) begin
      decision = FORCE_WR;
    end else if (bus.rd_req) begin
      decision = RD;
    end else if (!queue_empty) begin
      decision = WR;
    end
  end

  // Queue storage has no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk_50) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.wr_addr;
      q_data[wr_ptr] <= bus.wr_data;
      q_be[wr_ptr]   <= bus.wr_be;
    end
  end

  // The state register holds this cycle's decision for exactly one cycle.
  // RAM strobes are registered together with the state.
  // rd_pending marks the cycle in which ram_q holds the word fetched by the
  // previous RD cycle.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      rd_streak         <= '0;
      rd_pending        <= 1'b0;
      bus.rd_valid      <= 1'b0;
      bus.rd_data       <= '0;
      bus.wr_drop       <= 1'b0;
      bus.ram_wraddress <= '0;
      bus.ram_data      <= '0;
      bus.ram_byteena   <= '0;
      bus.ram_wren      <= 1'b0;
      bus.ram_rdaddress <= '0;
      bus.ram_rden      <= 1'b0;
    end else begin
      state        <= decision;
      bus.ram_wren <= pop;
      bus.ram_rden <= (decision == RD);
      bus.wr_drop  <= bus.wr_req && !bus.wr_ready;

      if (decision == RD) begin
        bus.ram_rdaddress <= bus.rd_addr;
        if (!streak_full) begin
          rd_streak <= rd_streak + 1'b1;
        end
      end else begin
        rd_streak <= '0;
      end

      if (pop) begin
        bus.ram_wraddress <= q_addr[rd_ptr];
        bus.ram_data      <= q_data[rd_ptr];
        bus.ram_byteena   <= q_be[rd_ptr];
        rd_ptr            <= rd_ptr + 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      rd_pending   <= (state == RD);
      bus.rd_valid <= rd_pending;
      if (rd_pending) begin
        bus.rd_data <= bus.ram_q;
      end
    end
  end

`ifdef FB_ARB_STATS_EN
  // The drop counter steps on the same edge that raises the wr_drop pulse.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      bus.stat_drop_cnt  <= '0;
      bus.stat_force_cnt <= '0;
    end else begin
      if (bus.wr_req && !bus.wr_ready && (bus.stat_drop_cnt != 16'hFFFF)) begin
        bus.stat_drop_cnt <= bus.stat_drop_cnt + 1'b1;
      end
      if ((decision == FORCE_WR) && (bus.stat_force_cnt != 16'hFFFF)) begin
        bus.stat_force_cnt <= bus.stat_force_cnt + 1'b1;
      end
    end
  end
`else
  assign bus.stat_drop_cnt  = '0;
  assign bus.stat_force_cnt = '0;
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
//   Drives fb_port_arbiter through directed scenarios and then a randomized
//   phase. Every cycle is checked against a transaction-level reference model.
//   The model keeps a queue of pending writes, an integer read-streak counter,
//   and events scheduled by cycle number. Read addresses (0x0000-0x00FF) and
//   write addresses (0x2000 and above) are kept disjoint, so read data always
//   comes from the fixed preload pattern.
`timescale 1ns/1ps
module tb_fb_port_arbiter;
  localparam int DEPTH = 4;
  localparam int MAXB  = 8;
`ifdef FB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk_50 = 1'b0;
  logic reset_n;
  always #10 clk_50 = ~clk_50;

  fb_port_arbiter_if bus ();

  fb_port_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_RD_BURST(MAXB)) dut (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference-model state
  wr_t         wq[$];
  wr_t         wsched[int];
  logic [15:0] rsched[int];
  logic [31:0] vsched[int];
  bit          dsched[int];
  int          streak;
  int          drops;
  int          forces;
  int          cyc;
  bit          model_valid;
  logic [31:0] last_rdata;

  // Counters for scenario checks and the summary line
  int tests_run;
  int tests_failed;
  int wren_seen;
  int valid_seen;
  int drop_seen;
  bit obs_rd_ready;

  logic [31:0] mem [0:65535];

  function automatic logic [31:0] preload(input logic [15:0] a);
    if (a == 16'h0010) return 32'hCAFEBABE;
    return {a ^ 16'h5A5A, a};
  endfunction

  function automatic logic [15:0] exp_stat(input int n);
    if (!STATS) return 16'h0;
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  // RAM model: byte-enabled write, one-cycle read latency. The read region
  // returns the preload pattern.
  always @(posedge clk_50) begin
    if (bus.ram_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_byteena[b]) mem[bus.ram_wraddress][8*b +: 8] <= bus.ram_data[8*b +: 8];
      end
    end
    if (bus.ram_rden) begin
      bus.ram_q <= (bus.ram_rdaddress < 16'h0100) ? preload(bus.ram_rdaddress) : mem[bus.ram_rdaddress];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle. Drive inputs at the falling edge, let them settle, and
  // compare every output with the model's view of this cycle. Then advance
  // the model across the next rising edge.
  task automatic applyStimulus(input bit rst_n, input bit wreq, input logic [15:0] waddr,
                               input logic [31:0] wdata, input logic [3:0] wbe,
                               input bit rreq, input logic [15:0] raddr);
    bit  force_wr;
    bit  room;
    wr_t e;
    @(negedge clk_50);
    reset_n     = rst_n;
    bus.wr_req  = wreq;
    bus.wr_addr = waddr;
    bus.wr_data = wdata;
    bus.wr_be   = wbe;
    bus.rd_req  = rreq;
    bus.rd_addr = raddr;
    #1;
    obs_rd_ready = bus.rd_ready;
    if (bus.ram_wren === 1'b1) wren_seen++;
    if (bus.rd_valid === 1'b1) valid_seen++;
    if (bus.wr_drop === 1'b1) drop_seen++;

    force_wr = (streak == MAXB) && (wq.size() > 0);
    room     = (wq.size() < DEPTH);

    if (model_valid) begin
      checkOutput("rd_ready", bus.rd_ready, rreq && !force_wr);
      checkOutput("wr_ready", bus.wr_ready, room);
      checkOutput("ram_wren", bus.ram_wren, wsched.exists(cyc));
      if (wsched.exists(cyc)) begin
        e = wsched[cyc];
        checkOutput("ram_wraddress", bus.ram_wraddress, e.addr);
        checkOutput("ram_data", bus.ram_data, e.data);
        checkOutput("ram_byteena", bus.ram_byteena, e.be);
      end
      checkOutput("ram_rden", bus.ram_rden, rsched.exists(cyc));
      if (rsched.exists(cyc)) checkOutput("ram_rdaddress", bus.ram_rdaddress, rsched[cyc]);
      checkOutput("rd_valid", bus.rd_valid, vsched.exists(cyc));
      if (vsched.exists(cyc)) last_rdata = vsched[cyc];
      checkOutput("rd_data", bus.rd_data, last_rdata);
      checkOutput("wr_drop", bus.wr_drop, dsched.exists(cyc));
      checkOutput("stat_drop_cnt", bus.stat_drop_cnt, exp_stat(drops));
      checkOutput("stat_force_cnt", bus.stat_force_cnt, exp_stat(forces));
    end
    wsched.delete(cyc);
    rsched.delete(cyc);
    vsched.delete(cyc);
    dsched.delete(cyc);

    if (!rst_n) begin
      wq.delete();
      wsched.delete();
      rsched.delete();
      vsched.delete();
      dsched.delete();
      streak      = 0;
      drops       = 0;
      forces      = 0;
      last_rdata  = '0;
      model_valid = 1'b1;
    end else begin
      if (force_wr || (!rreq && wq.size() > 0)) begin
        wsched[cyc + 1] = wq.pop_front();
        if (force_wr) forces++;
      end
      if (rreq && !force_wr) begin
        rsched[cyc + 1] = raddr;
        vsched[cyc + 3] = preload(raddr);
        if (streak < MAXB) streak++;
      end else begin
        streak = 0;
      end
      if (wreq && room) begin
        e.addr = waddr;
        e.data = wdata;
        e.be   = wbe;
        wq.push_back(e);
      end
      if (wreq && !room) begin
        dsched[cyc + 1] = 1'b1;
        drops++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input bit rst_n);
    applyStimulus(rst_n, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0);
  endtask

  task automatic freshStart();
    idle(1'b0);
    idle(1'b1);
    wren_seen  = 0;
    valid_seen = 0;
    drop_seen  = 0;
  endtask

  initial begin
    int grants;
    int zeros;
    bit seen_zero;
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    model_valid  = 1'b0;
    streak       = 0;
    drops        = 0;
    forces       = 0;
    last_rdata   = '0;
    reset_n      = 1'b0;
    bus.wr_req   = 1'b0;
    bus.rd_req   = 1'b0;
    idle(1'b0);

    // Single read from 0x0010
    freshStart();
    applyStimulus(1'b1, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0010);
    checkOutput("single_read_rd_ready", obs_rd_ready, 1);
    repeat (5) idle(1'b1);
    checkOutput("single_read_data", bus.rd_data, 32'hCAFEBABE);
    checkOutput("single_read_valid_pulses", valid_seen, 1);

    // Four writes with no reads, drained in FIFO order
    freshStart();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'h2000 + i), $urandom, 4'(i + 1), 1'b0, 16'h0);
    end
    repeat (6) idle(1'b1);
    checkOutput("fifo_order_wren_pulses", wren_seen, 4);

    // Continuous reads with one queued write
    freshStart();
    grants    = 0;
    zeros     = 0;
    seen_zero = 1'b0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, i == 0, 16'h2100, 32'h1234_5678, 4'hF, 1'b1, 16'(16'h0020 + i));
      if (!obs_rd_ready) begin
        zeros++;
        seen_zero = 1'b1;
      end else if (!seen_zero) begin
        grants++;
      end
    end
    checkOutput("burst_grants_before_force", grants, MAXB);
    checkOutput("burst_force_cycles", zeros, 1);
    checkOutput("burst_stat_force", bus.stat_force_cnt, STATS ? 1 : 0);

    // Five writes into a four-entry queue while reads hold the RAM
    freshStart();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'h2200 + i), $urandom, 4'hF, 1'b1, 16'(i));
    end
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0040);
    checkOutput("full_drop_pulses", drop_seen, 1);
    checkOutput("full_stat_drop", bus.stat_drop_cnt, STATS ? 1 : 0);

    // Reset one cycle after an accepted read, with a write also queued
    freshStart();
    applyStimulus(1'b1, 1'b1, 16'h2300, 32'hDEAD_BEEF, 4'hF, 1'b1, 16'h0050);
    idle(1'b0);
    idle(1'b1);
    checkOutput("rst_mid_wr_ready", bus.wr_ready, 1);
    checkOutput("rst_mid_ram_wraddress", bus.ram_wraddress, 0);
    checkOutput("rst_mid_ram_data", bus.ram_data, 0);
    checkOutput("rst_mid_ram_byteena", bus.ram_byteena, 0);
    checkOutput("rst_mid_ram_rdaddress", bus.ram_rdaddress, 0);
    checkOutput("rst_mid_rd_data", bus.rd_data, 0);
    repeat (4) idle(1'b1);
    checkOutput("rst_mid_no_rd_valid", valid_seen, 0);
    checkOutput("rst_mid_queue_empty", wren_seen, 0);

    // Push and pop on the same edge with two entries queued
    freshStart();
    applyStimulus(1'b1, 1'b1, 16'h2400, 32'hA000_0001, 4'h1, 1'b1, 16'h0060);
    applyStimulus(1'b1, 1'b1, 16'h2401, 32'hA000_0002, 4'h3, 1'b1, 16'h0061);
    applyStimulus(1'b1, 1'b1, 16'h2402, 32'hA000_0003, 4'h7, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'h2403, 32'hA000_0004, 4'hF, 1'b1, 16'h0062);
    applyStimulus(1'b1, 1'b1, 16'h2404, 32'hA000_0005, 4'hE, 1'b1, 16'h0063);
    applyStimulus(1'b1, 1'b1, 16'h2405, 32'hA000_0006, 4'hC, 1'b1, 16'h0064);
    repeat (8) idle(1'b1);
    checkOutput("same_edge_wren_pulses", wren_seen, 5);

    // Randomized traffic with occasional resets
    freshStart();
    for (int i = 0; i < 2000; i++) begin
      bit          r_rst;
      bit          r_wr;
      bit          r_rd;
      logic [15:0] r_waddr;
      logic [15:0] r_raddr;
      logic [3:0]  r_be;
      r_rst   = ($urandom_range(0, 299) != 0);
      r_wr    = 1'($urandom_range(0, 1));
      r_rd    = ($urandom_range(0, 9) < 7);
      r_waddr = 16'(16'h2000 | $urandom_range(0, 255));
      r_raddr = 16'($urandom_range(0, 255));
      r_be    = 4'($urandom_range(1, 15));
      applyStimulus(r_rst, r_wr, r_waddr, $urandom, r_be, r_rd, r_raddr);
    end
    repeat (6) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
